// File: rtl/qos_wrr_scheduler_pkg.sv
// Shared definitions for the qos weighted round-robin scheduler.
// Holds the default sizing constants used across the qos block and the
// scheduler FSM state encoding.
package qos_wrr_scheduler_pkg;

  localparam int DEF_QUEUE_QUANTITY = 4;   // number of FIFO queues scheduled
  localparam int DEF_WEIGHT_BITS    = 7;   // weight/credit field width (holds 0..64)
  localparam int DEF_MAX_WEIGHT     = 64;  // weights above this saturate
  localparam int DEF_SEL_BITS       = 2;   // log2(DEF_QUEUE_QUANTITY)

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/qos_wrr_scheduler_if.sv
// Scheduler <-> FIFO-bank / output-mux interface.
//   empty    : per-queue FIFO empty flags (bit i = queue i)
//   weights  : packed per-queue weights, queue i at [i*WEIGHT_BITS +: WEIGHT_BITS]
//   out_full : downstream FIFO almost-full
//   pop      : one-hot FIFO read enables (combinational)
//   sel      : index of the queue being served (registered)
//   busy     : high while a turn is active
//   credit   : pops remaining in the current turn
// master = scheduler side, slave = FIFO bank / mux side.
interface qos_wrr_scheduler_if
  import qos_wrr_scheduler_pkg::*;
#(
  parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
  parameter int WEIGHT_BITS    = DEF_WEIGHT_BITS,
  parameter int SEL_BITS       = DEF_SEL_BITS
);

  logic [QUEUE_QUANTITY-1:0]             empty;
  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights;
  logic                                  out_full;
  logic [QUEUE_QUANTITY-1:0]             pop;
  logic [SEL_BITS-1:0]                   sel;
  logic                                  busy;
  logic [WEIGHT_BITS-1:0]                credit;

  modport master (
    input  empty, weights, out_full,
    output pop, sel, busy, credit
  );

  modport slave (
    output empty, weights, out_full,
    input  pop, sel, busy, credit
  );

endinterface

// File: rtl/qos_wrr_scheduler_rr_search.sv
// qos_rr_search: combinational rotate-and-priority-encode.
// Finds the first set bit of 'eligible' in the order last+1, last+2, ...
// wrapping, with 'last' itself examined last.
//   eligible : per-queue eligibility vector
//   last     : index the search rotates from
//   found    : some queue is eligible
//   next_idx : first eligible index in search order (holds 'last' when none)
module qos_rr_search
  import qos_wrr_scheduler_pkg::*;
#(
  parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
  parameter int SEL_BITS       = DEF_SEL_BITS
) (
  input  logic [QUEUE_QUANTITY-1:0] eligible,
  input  logic [SEL_BITS-1:0]       last,
  output logic                      found,
  output logic [SEL_BITS-1:0]       next_idx
);

  logic [SEL_BITS-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave it unassigned and infer a latch.
    found    = 1'b0;
    next_idx = last;
    cand     = '0;
    for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
      cand = SEL_BITS'((int'(last) + k) % QUEUE_QUANTITY);
      if (!found && eligible[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

endmodule

// File: rtl/qos_wrr_scheduler.sv
// qos_wrr_scheduler: weighted round-robin pop scheduler for the qos FIFO bank.
// Each eligible queue (non-empty, non-zero weight) gets a turn of up to
// min(weight, MAX_WEIGHT) consecutive pops; turns rotate round-robin.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   enb  : global enable; low freezes all state and forces pop=0
//   bus  : scheduler side of qos_wrr_scheduler_if (empty/weights/out_full in,
//          pop/sel/busy/credit out)
module qos_wrr_scheduler
  import qos_wrr_scheduler_pkg::*;
#(
  parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
  parameter int WEIGHT_BITS    = DEF_WEIGHT_BITS,
  parameter int MAX_WEIGHT     = DEF_MAX_WEIGHT,
  parameter int SEL_BITS       = DEF_SEL_BITS
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 enb,
  qos_wrr_scheduler_if.master bus
);

  state_e                    state_q, state_d;
  logic [SEL_BITS-1:0]       sel_q, sel_d;
  logic [SEL_BITS-1:0]       last_q, last_d;
  logic [WEIGHT_BITS-1:0]    credit_q, credit_d;
  logic [QUEUE_QUANTITY-1:0] pop_d;

  logic [WEIGHT_BITS-1:0]    weight [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] eligible;
  logic [SEL_BITS-1:0]       search_last;
  logic [SEL_BITS-1:0]       found_idx;
  logic                      found;
  logic [WEIGHT_BITS-1:0]    load_credit;
  logic                      turn_end;

  always_comb begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      weight[i]   = bus.weights[i*WEIGHT_BITS +: WEIGHT_BITS];
      eligible[i] = !bus.empty[i] && (weight[i] != '0);
    end
  end

  // While serving, a turn that ends this cycle rotates from the queue being
  // served; the just-popped queue's empty flag is not yet updated, so it may
  // be picked again and will then drain on the following cycle.
  assign search_last = (state_q == SERVE) ? sel_q : last_q;

  qos_rr_search #(
    .QUEUE_QUANTITY(QUEUE_QUANTITY),
    .SEL_BITS      (SEL_BITS)
  ) u_search (
    .eligible(eligible),
    .last    (search_last),
    .found   (found),
    .next_idx(found_idx)
  );

  assign load_credit = (weight[found_idx] > WEIGHT_BITS'(MAX_WEIGHT))
                     ? WEIGHT_BITS'(MAX_WEIGHT) : weight[found_idx];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    credit_d = credit_q;
    last_d   = last_q;
    pop_d    = '0;
    turn_end = 1'b0;

    if (enb) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d  = SERVE;
            sel_d    = found_idx;
            credit_d = load_credit;
          end
        end
        SERVE: begin
          if (bus.empty[sel_q]) begin
            // Drained early: remaining credit is forfeited.
            turn_end = 1'b1;
          end else if (!bus.out_full) begin
            pop_d[sel_q] = 1'b1;
            if (credit_q > WEIGHT_BITS'(1)) credit_d = credit_q - WEIGHT_BITS'(1);
            else                            turn_end = 1'b1;
          end
          // out_full with data pending: stall, everything held.

          if (turn_end) begin
            last_d = sel_q;
            if (found) begin
              sel_d    = found_idx;
              credit_d = load_credit;
            end else begin
              state_d  = IDLE;
              credit_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all state uses non-blocking assignment so every register samples
    // the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      credit_q <= '0;
      last_q   <= SEL_BITS'(QUEUE_QUANTITY - 1);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      credit_q <= credit_d;
      last_q   <= last_d;
    end
  end

  // pop is derived from registered state plus live inputs; asynchronous reset
  // clears state_q immediately, so pop drops with rst.
  assign bus.pop    = pop_d;
  assign bus.sel    = sel_q;
  assign bus.busy   = (state_q == SERVE);
  assign bus.credit = credit_q;

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Self-checking bench for qos_wrr_scheduler. A transaction-level model keeps
// "which queue owns the turn, how many pops are left, who went last" and
// predicts pop/sel/busy/credit each cycle; the FIFO bank is modelled as
// per-queue occupancy counts that the observed pops drain.
module tb_qos_wrr_scheduler;
  import qos_wrr_scheduler_pkg::*;

  localparam int N    = DEF_QUEUE_QUANTITY;
  localparam int WB   = DEF_WEIGHT_BITS;
  localparam int MAXW = DEF_MAX_WEIGHT;
  localparam int INF  = 1000000;

  logic clk = 1'b0;
  logic rst;
  logic enb;

  qos_wrr_scheduler_if bus ();

  qos_wrr_scheduler dut (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int cnt [N];
  int w   [N];
  bit rand_refill = 1'b0;

  bit m_active;
  int m_q, m_cred, m_last;
  int pop_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.empty[i]             = (cnt[i] == 0);
      bus.weights[i*WB +: WB]  = WB'(w[i]);
    end
  endtask

  function automatic bit eligible(input int i);
    return (cnt[i] > 0) && (w[i] != 0);
  endfunction

  function automatic int find_from(input int from);
    for (int k = 1; k <= N; k++) begin
      int c = (from + k) % N;
      if (eligible(c)) return c;
    end
    return -1;
  endfunction

  function automatic int sat(input int x);
    return (x > MAXW) ? MAXW : x;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_q      = 0;
    m_cred   = 0;
    m_last   = N - 1;
  endtask

  task automatic start_turn(input int f);
    m_active = 1'b1;
    m_q      = f;
    m_cred   = sat(w[f]);
  endtask

  // Advance the model across one clock edge; 'popped' is the queue popped
  // this cycle or -1.
  task automatic model_step(input int popped);
    int f;
    if (!rst || !enb) return;
    if (!m_active) begin
      f = find_from(m_last);
      if (f >= 0) start_turn(f);
    end else if (popped >= 0 && m_cred > 1) begin
      m_cred--;
    end else if (popped >= 0 || cnt[m_q] == 0) begin
      m_last = m_q;
      f = find_from(m_q);
      if (f >= 0) start_turn(f);
      else begin
        m_active = 1'b0;
        m_cred   = 0;
      end
    end
  endtask

  // Entered and left at posedge+1 with inputs already applied.
  task automatic cycle();
    int            ep;
    logic [N-1:0]  epv;
    logic [N-1:0]  obs_pop;
    #3;
    ep  = (rst && enb && m_active && cnt[m_q] > 0 && !bus.out_full) ? m_q : -1;
    epv = (ep >= 0) ? (N'(1) << ep) : '0;
    obs_pop = bus.pop;
    check("pop",     32'(obs_pop),               32'(epv));
    check("sel",     32'(bus.sel),               32'(m_q));
    check("busy",    32'(bus.busy),              32'(m_active));
    check("credit",  32'(bus.credit),            32'(m_cred));
    check("onehot0", 32'($onehot0(obs_pop)),     32'(1));
    if (obs_pop != '0) pop_log.push_back($clog2(obs_pop));
    model_step(ep);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (obs_pop[i] && cnt[i] > 0 && cnt[i] < INF) cnt[i]--;
    if (rand_refill)
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) cnt[i] += int'($urandom_range(1, 3));
    apply();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    model_reset();
    run(2);
    rst = 1'b1;
    pop_log.delete();
  endtask

  // Bounded wait until the model reaches a given queue/credit mid-turn.
  task automatic wait_turn(input string tag, input int q, input int cr);
    bit reached = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (m_active && m_q == q && m_cred == cr) begin
        reached = 1'b1;
        break;
      end
      cycle();
    end
    check(tag, 32'(reached), 32'(1));
  endtask

  // Expected queue for the n-th pop under weights {1,2,3,4}.
  function automatic int steady_q(input int n);
    int r = n % 10;
    if (r < 1) return 0;
    if (r < 3) return 1;
    if (r < 6) return 2;
    return 3;
  endfunction

  initial begin
    int n1, run3, best3;

    rst          = 1'b0;
    enb          = 1'b1;
    bus.out_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = INF;
      w[i]   = i + 1;
    end
    apply();
    model_reset();
    @(posedge clk);
    #1;

    // 1. Reset state and first-pop latency.
    run(3);
    check("t1_rst_pop",    32'(bus.pop),    32'(0));
    check("t1_rst_sel",    32'(bus.sel),    32'(0));
    check("t1_rst_busy",   32'(bus.busy),   32'(0));
    check("t1_rst_credit", 32'(bus.credit), 32'(0));
    rst = 1'b1;
    pop_log.delete();
    cycle();
    check("t1_busy_after_1", 32'(bus.busy), 32'(1));
    check("t1_first_pop",    32'(bus.pop),  32'(4'b0001));

    // 2. Steady WRR, no bubbles.
    run(20);
    check("t2_pop_count", 32'(pop_log.size()), 32'(20));
    for (int j = 0; j < 20 && j < pop_log.size(); j++)
      check($sformatf("t2_seq%0d", j), 32'(pop_log[j]), 32'(steady_q(j)));

    // 3. Disabled queue and saturating-length turn.
    w[0] = 2; w[1] = 0; w[2] = 1; w[3] = 64;
    apply();
    reset_dut();
    run(2 * 67 + 5);
    n1 = 0; run3 = 0; best3 = 0;
    foreach (pop_log[j]) begin
      if (pop_log[j] == 1) n1++;
      run3  = (pop_log[j] == 3) ? run3 + 1 : 0;
      best3 = (run3 > best3) ? run3 : best3;
    end
    check("t3_q1_pops",   32'(n1),    32'(0));
    check("t3_q3_streak", 32'(best3), 32'(64));

    // 4. Backpressure during q2's turn with credit 2.
    for (int i = 0; i < N; i++) w[i] = i + 1;
    apply();
    reset_dut();
    wait_turn("t4_reach", 2, 2);
    bus.out_full = 1'b1;
    run(3);
    check("t4_credit_held", 32'(bus.credit), 32'(2));
    check("t4_sel_held",    32'(bus.sel),    32'(2));
    bus.out_full = 1'b0;
    pop_log.delete();
    run(2);
    check("t4_remaining", 32'(pop_log.size()), 32'(2));
    for (int j = 0; j < pop_log.size(); j++)
      check("t4_remaining_q", 32'(pop_log[j]), 32'(2));

    // 5. Early drain of q1, then all empty -> IDLE.
    w[0] = 1; w[1] = 4; w[2] = 1; w[3] = 1;
    for (int i = 0; i < N; i++) cnt[i] = 1;
    apply();
    reset_dut();
    run(10);
    check("t5_pops", 32'(pop_log.size()), 32'(4));
    check("t5_idle", 32'(bus.busy),       32'(0));

    // 6a. Asynchronous reset mid-turn of q3.
    for (int i = 0; i < N; i++) begin
      cnt[i] = INF;
      w[i]   = i + 1;
    end
    apply();
    reset_dut();
    wait_turn("t6_reach_q3", 3, 3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_pop",  32'(bus.pop),  32'(0));
    check("t6_async_sel",  32'(bus.sel),  32'(0));
    check("t6_async_busy", 32'(bus.busy), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b1;
    pop_log.delete();
    run(2);
    check("t6_restart_n", 32'(pop_log.size()), 32'(1));
    if (pop_log.size() > 0) check("t6_restart_q0", 32'(pop_log[0]), 32'(0));

    // 6b. enb low for 5 cycles mid-turn.
    wait_turn("t6_reach_q2", 2, 2);
    enb = 1'b0;
    run(5);
    check("t6_frozen_sel",    32'(bus.sel),    32'(2));
    check("t6_frozen_credit", 32'(bus.credit), 32'(2));
    enb = 1'b1;
    pop_log.delete();
    run(3);
    check("t6_resume_n", 32'(pop_log.size()), 32'(3));
    if (pop_log.size() == 3) begin
      check("t6_resume_0", 32'(pop_log[0]), 32'(2));
      check("t6_resume_1", 32'(pop_log[1]), 32'(2));
      check("t6_resume_2", 32'(pop_log[2]), 32'(3));
    end

    // 7. Randomized traffic, backpressure, enable and weight changes.
    for (int i = 0; i < N; i++) cnt[i] = int'($urandom_range(0, 4));
    apply();
    reset_dut();
    rand_refill = 1'b1;
    for (int c = 0; c < 600; c++) begin
      bus.out_full = ($urandom_range(0, 3) == 0);
      enb          = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        int q = int'($urandom_range(0, N - 1));
        w[q] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65, 127))
                                           : int'($urandom_range(0, 5));
      end
      apply();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qos_wrr_scheduler.md
Name: qos_wrr_scheduler

Overview:
- Weighted round-robin scheduler that decides which of the qos FIFO queues is popped each cycle.
- Drives one-hot pop strobes into the QUEUE_QUANTITY FIFO read enables and the selected index into the output mux.
- Per-queue weights (1..MAX_WEIGHT pops per turn) come from the arbitration configuration.
- Sits between the FIFO bank and the downstream output FIFO and honours that FIFO's almost-full backpressure.

Parameters:
QUEUE_QUANTITY, 4, number of FIFO queues scheduled
WEIGHT_BITS, 7, width of each weight/credit field (holds 0..64)
MAX_WEIGHT, 64, largest legal weight; larger values are saturated to 64
SEL_BITS, 2, width of queue index (log2 QUEUE_QUANTITY)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
enb  input  1  global enable; low freezes all state and forces pop=0
empty  input  QUEUE_QUANTITY  per-queue FIFO empty flags, bit i = queue i
weights  input  QUEUE_QUANTITY*WEIGHT_BITS  packed weights, queue i at [i*WEIGHT_BITS +: WEIGHT_BITS]; 0 = queue disabled
out_full  input  1  downstream FIFO almost-full; stalls popping
pop  output  QUEUE_QUANTITY  one-hot read enable to the selected FIFO; combinational
sel  output  SEL_BITS  index of queue currently served; registered
busy  output  1  high while in SERVE
credit  output  WEIGHT_BITS  remaining pops for the current turn; debug/observability

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sel=0, credit=0, busy=0, last=QUEUE_QUANTITY-1, so the first search starts at q0. pop=0 while rst=0 regardless of other inputs.
- Eligible(i) = !empty[i] && weights[i]!=0.
- Search order from last: last+1, last+2, ... wrapping modulo QUEUE_QUANTITY, with last itself checked last.
- States: IDLE, SERVE.
- IDLE:
  - pop=0.
  - If enb and any queue is eligible: load sel=first eligible in search order, credit=min(weight,MAX_WEIGHT), go to SERVE.
  - The first pop happens on the next cycle (1-cycle start latency).
- SERVE:
  - pop[sel] = enb && !empty[sel] && !out_full; all other pop bits are 0.
  - Pop with credit>1: credit-1; stay on sel.
  - Pop with credit==1 (turn complete): last=sel. Re-search for an eligible queue, excluding sel's empty flag change not yet visible.
    - If one is found: load the new sel/credit in the same edge. There is no bubble between turns.
    - If none is found: go to IDLE.
  - empty[sel]=1 while enb=1 (queue drained early): no pop, the remaining credit is forfeited, last=sel, and the same re-search/IDLE rule applies. This costs 1 bubble cycle.
  - out_full=1 with empty[sel]=0: stall. pop=0; sel, credit and state are held.
- enb=0 in any state: pop=0 and every register holds.
- Weight changes take effect only when a queue's credit is next loaded; an active turn keeps its loaded credit.
- Weight changed to 0 during a turn: the current turn completes, then the queue is skipped.
- pop is never asserted on an empty queue, and never asserted while out_full=1.
- pop is always zero or one-hot.
- Reset asserted mid-SERVE: pop drops to 0 immediately (asynchronously), all state returns to reset values, and after release scheduling restarts from q0.

Decomposition:
- Shared qos package/include:
  - State encodings (IDLE=1'b0, SERVE=1'b1).
  - Default QUEUE_QUANTITY, WEIGHT_BITS, MAX_WEIGHT and SEL_BITS constants shared with qos.
- One sub-module, qos_rr_search:
  - Combinational rotate-and-priority-encode.
  - Inputs: eligible vector and last index. Outputs: found flag and next index.
  - Reused later by the qos arbitration-table logic.

Test Plan:
1. Reset check: hold rst=0 with all queues non-empty → pop=0, sel=0, busy=0, credit=0. Release rst with weights={1,2,3,4} → busy=1 after 1 cycle, first pop=4'b0001.
2. Steady WRR: all queues always non-empty, out_full=0, weights q0..q3={1,2,3,4} → repeating pop sequence q0,q1,q1,q2,q2,q2,q3,q3,q3,q3. That is 10 pops per 10 cycles with no bubbles, and sel wraps 3→0.
3. Disabled queue: weights={2,0,1,64}, all non-empty → q1 is never popped. q3 receives 64 consecutive pops and credit counts 64→1.
4. Backpressure: out_full=1 for 3 cycles during q2's turn with credit=2 → pop=0 for 3 cycles, credit stays 2, then q2 completes its 2 remaining pops.
5. Early drain: q1 has weight 4 but only 1 entry → 1 pop, 1 bubble cycle with credit forfeited, then the turn moves to q2. When all queues are empty, the block returns to IDLE and busy=0.
6. Mid-operation reset and enable: rst=0 asserted mid-turn of q3 → pop=0 the same cycle and sel=0 after release. Separately, enb=0 for 5 cycles mid-turn → pop=0, sel and credit frozen, and the block resumes exactly where it stopped.
